// File: rtl/ixu_regfile.sv
// ixu_regfile: 31-entry integer register file (x0 hardwired to zero) with
// optional write-to-read forwarding and a per-register busy scoreboard that
// tracks outstanding producers between issue and writeback.
module ixu_regfile #(
  parameter int BYPASS = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  input  logic        wr_en,
  input  logic [4:0]  rd,
  input  logic [31:0] data_in,
  input  logic        issue_en,
  input  logic [4:0]  issue_rd,
  output logic        rs1_busy,
  output logic        rs2_busy,
  output logic        issue_hazard,
  output logic [31:0] busy_vec
);

  // Index 0 has no storage, so the array starts at 1.
  logic [31:0] regs_q [1:31];
  logic [31:0] regs_d [1:31];
  logic [31:0] busy_q;
  logic [31:0] busy_d;

  logic        wr_valid;
  logic        fwd1;
  logic        fwd2;
  logic [31:0] stored1;
  logic [31:0] stored2;

  assign wr_valid = wr_en && (rd != 5'd0);
  assign fwd1     = wr_valid && (rd == rs1_addr);
  assign fwd2     = wr_valid && (rd == rs2_addr);

  // Next register contents: only the addressed entry takes data_in.
  always_comb begin
    for (int i = 1; i < 32; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_valid && (rd == 5'(i))) begin
        regs_d[i] = data_in;
      end
    end
  end

  // Next busy bits: writeback clears first, then issue sets so a same-index
  // issue wins and tracks the new producer; bit 0 is never set.
  always_comb begin
    busy_d = busy_q;
    if (wr_valid) begin
      busy_d[rd] = 1'b0;
    end
    if (issue_en && (issue_rd != 5'd0)) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Register and scoreboard state, cleared immediately on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= 32'd0;
      end
      busy_q <= 32'd0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q <= busy_d;
    end
  end

  // Stored-value read muxes; index 0 falls through to zero.
  always_comb begin
    stored1 = 32'd0;
    stored2 = 32'd0;
    for (int i = 1; i < 32; i++) begin
      if (rs1_addr == 5'(i)) begin
        stored1 = regs_q[i];
      end
      if (rs2_addr == 5'(i)) begin
        stored2 = regs_q[i];
      end
    end
  end

  // Read data, optionally forwarded from the writeback port this cycle.
  always_comb begin
    rs1_data = stored1;
    rs2_data = stored2;
    if (BYPASS != 0) begin
      if (fwd1) begin
        rs1_data = data_in;
      end
      if (fwd2) begin
        rs2_data = data_in;
      end
    end
  end

  // Operand busy flags: with forwarding an arriving writeback releases the
  // operand now; without it the operand stays busy until the value is stored.
  always_comb begin
    if (BYPASS != 0) begin
      rs1_busy = busy_q[rs1_addr] && !(wr_en && (rd == rs1_addr));
      rs2_busy = busy_q[rs2_addr] && !(wr_en && (rd == rs2_addr));
    end else begin
      rs1_busy = busy_q[rs1_addr] || fwd1;
      rs2_busy = busy_q[rs2_addr] || fwd2;
    end
  end

  // WAW hazard: issuing to a register whose producer is still outstanding,
  // unless that producer is writing back in this same cycle.
  always_comb begin
    issue_hazard = issue_en && (issue_rd != 5'd0) && busy_q[issue_rd] &&
                   !(wr_en && (rd == issue_rd));
  end

  assign busy_vec = busy_q;

endmodule

// File: tb/tb_ixu_regfile.sv
// tb_ixu_regfile: directed test of ixu_regfile, with one instance using
// forwarding (BYPASS=1) and one without (BYPASS=0) sharing the same inputs.
module tb_ixu_regfile;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        wr_en;
  logic [4:0]  rd;
  logic [31:0] data_in;
  logic        issue_en;
  logic [4:0]  issue_rd;

  logic [31:0] b1_rs1_data, b1_rs2_data, b1_busy_vec;
  logic        b1_rs1_busy, b1_rs2_busy, b1_hazard;
  logic [31:0] b0_rs1_data, b0_rs2_data, b0_busy_vec;
  logic        b0_rs1_busy, b0_rs2_busy, b0_hazard;

  int total = 0;
  int bad   = 0;

  ixu_regfile #(.BYPASS(1)) dut_byp (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(b1_rs1_data), .rs2_data(b1_rs2_data),
    .wr_en(wr_en), .rd(rd), .data_in(data_in),
    .issue_en(issue_en), .issue_rd(issue_rd),
    .rs1_busy(b1_rs1_busy), .rs2_busy(b1_rs2_busy),
    .issue_hazard(b1_hazard), .busy_vec(b1_busy_vec)
  );

  ixu_regfile #(.BYPASS(0)) dut_nobyp (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(b0_rs1_data), .rs2_data(b0_rs2_data),
    .wr_en(wr_en), .rd(rd), .data_in(data_in),
    .issue_en(issue_en), .issue_rd(issue_rd),
    .rs1_busy(b0_rs1_busy), .rs2_busy(b0_rs2_busy),
    .issue_hazard(b0_hazard), .busy_vec(b0_busy_vec)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [4:0] wa,
                               input logic [31:0] wd, input logic ie,
                               input logic [4:0] ia, input logic [4:0] a1,
                               input logic [4:0] a2);
    wr_en    = we;
    rd       = wa;
    data_in  = wd;
    issue_en = ie;
    issue_rd = ia;
    rs1_addr = a1;
    rs2_addr = a2;
    #1;
  endtask

  // Advance past the next rising edge, leaving time before new stimulus.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    $display("[TB] start");

    // Writes and issues under reset must be ignored.
    tick();
    applyStimulus(1'b1, 5'd4, 32'hCAFE0004, 1'b1, 5'd4, 5'd0, 5'd0);
    tick();
    checkOutput("rst_busy_b1", b1_busy_vec, 32'd0);
    checkOutput("rst_busy_b0", b0_busy_vec, 32'd0);

    // All indices read zero on both ports.
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    for (int a = 0; a < 32; a++) begin
      rs1_addr = 5'(a);
      rs2_addr = 5'(31 - a);
      #1;
      checkOutput("rst_rd1_b1", b1_rs1_data, 32'd0);
      checkOutput("rst_rd2_b1", b1_rs2_data, 32'd0);
      checkOutput("rst_rd1_b0", b0_rs1_data, 32'd0);
      checkOutput("rst_rd2_b0", b0_rs2_data, 32'd0);
    end

    // Release reset between edges.
    #2 rst_n = 1'b1;
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd4, 5'd4);
    checkOutput("post_rst_r4_b1", b1_rs1_data, 32'd0);
    checkOutput("post_rst_busy_b1", b1_busy_vec, 32'd0);

    // Same-cycle forwarding of a write to rs1.
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd0);
    checkOutput("fwd_r5_b1", b1_rs1_data, 32'hDEADBEEF);
    checkOutput("fwd_r5_b0", b0_rs1_data, 32'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd5);
    checkOutput("stored_r5_b1", b1_rs1_data, 32'hDEADBEEF);
    checkOutput("stored_r5_b0", b0_rs1_data, 32'hDEADBEEF);
    checkOutput("same_addr_b1", b1_rs2_data, 32'hDEADBEEF);
    checkOutput("same_addr_b0", b0_rs2_data, 32'hDEADBEEF);

    // Writes and issues to index 0 have no effect.
    applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 5'd0);
    checkOutput("x0_fwd_b1", b1_rs1_data, 32'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    checkOutput("x0_rd1_b1", b1_rs1_data, 32'd0);
    checkOutput("x0_rd2_b0", b0_rs2_data, 32'd0);
    checkOutput("x0_busy_b1", b1_busy_vec, 32'd0);

    // Scoreboard lifetime of register 7.
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd0, 5'd7);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd7);
    checkOutput("r7_busyvec_b1", b1_busy_vec, 32'h0000_0080);
    checkOutput("r7_rs2busy_b1", {31'd0, b1_rs2_busy}, 32'd1);
    checkOutput("r7_rs2busy_b0", {31'd0, b0_rs2_busy}, 32'd1);
    tick();
    checkOutput("r7_still_b0", {31'd0, b0_rs2_busy}, 32'd1);
    tick();
    applyStimulus(1'b1, 5'd7, 32'h0000_0077, 1'b0, 5'd0, 5'd0, 5'd7);
    checkOutput("r7_wb_busy_b1", {31'd0, b1_rs2_busy}, 32'd0);
    checkOutput("r7_wb_busy_b0", {31'd0, b0_rs2_busy}, 32'd1);
    checkOutput("r7_wb_data_b1", b1_rs2_data, 32'h0000_0077);
    checkOutput("r7_wb_data_b0", b0_rs2_data, 32'd0);
    checkOutput("r7_wb_vec_b1", b1_busy_vec, 32'h0000_0080);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd7);
    checkOutput("r7_clr_vec_b1", b1_busy_vec, 32'd0);
    checkOutput("r7_clr_vec_b0", b0_busy_vec, 32'd0);
    checkOutput("r7_data_b0", b0_rs2_data, 32'h0000_0077);

    // Issue and writeback collide on register 9: set wins, no hazard.
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b1, 5'd9, 32'h0000_1234, 1'b1, 5'd9, 5'd9, 5'd0);
    checkOutput("r9_nohaz_b1", {31'd0, b1_hazard}, 32'd0);
    checkOutput("r9_nohaz_b0", {31'd0, b0_hazard}, 32'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd0);
    checkOutput("r9_haz_b1", {31'd0, b1_hazard}, 32'd1);
    checkOutput("r9_haz_b0", {31'd0, b0_hazard}, 32'd1);
    checkOutput("r9_vec_b1", b1_busy_vec, 32'h0000_0200);
    checkOutput("r9_data_b0", b0_rs1_data, 32'h0000_1234);

    // Issue 10 while register 9 writes back: both updates apply.
    applyStimulus(1'b1, 5'd9, 32'h0000_9999, 1'b1, 5'd10, 5'd0, 5'd0);
    checkOutput("r10_nohaz_b1", {31'd0, b1_hazard}, 32'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd10);
    checkOutput("r9r10_vec_b1", b1_busy_vec, 32'h0000_0400);
    checkOutput("r9r10_vec_b0", b0_busy_vec, 32'h0000_0400);
    checkOutput("r10_rs2busy_b1", {31'd0, b1_rs2_busy}, 32'd1);
    checkOutput("r9_rs1busy_b1", {31'd0, b1_rs1_busy}, 32'd0);
    checkOutput("r9_new_data_b1", b1_rs1_data, 32'h0000_9999);

    // Writeback to a non-busy register leaves the scoreboard alone.
    applyStimulus(1'b1, 5'd12, 32'h0000_0ABC, 1'b0, 5'd0, 5'd12, 5'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd12, 5'd0);
    checkOutput("r12_vec_b1", b1_busy_vec, 32'h0000_0400);
    checkOutput("r12_data_b0", b0_rs1_data, 32'h0000_0ABC);

    // Register 3 written and busy, then reset asserted mid-cycle.
    applyStimulus(1'b1, 5'd3, 32'h0000_0055, 1'b1, 5'd3, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd12);
    checkOutput("r3_data_b1", b1_rs1_data, 32'h0000_0055);
    checkOutput("r3_vec_b1", b1_busy_vec, 32'h0000_0408);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("arst_r3_b1", b1_rs1_data, 32'd0);
    checkOutput("arst_r3_b0", b0_rs1_data, 32'd0);
    checkOutput("arst_r12_b1", b1_rs2_data, 32'd0);
    checkOutput("arst_vec_b1", b1_busy_vec, 32'd0);
    checkOutput("arst_vec_b0", b0_busy_vec, 32'd0);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ixu_regfile.md
IXU_REGFILE -- requirements
Module: ixu_regfile

Interface
REQ-001 Parameter BYPASS, default 1: 1 = write-to-read forwarding in the same cycle; 0 = reads return stored value only.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 rs1_addr  input  5  read port 1 register index.
REQ-005 rs2_addr  input  5  read port 2 register index.
REQ-006 rs1_data  output  32  read port 1 data, combinational.
REQ-007 rs2_data  output  32  read port 2 data, combinational.
REQ-008 wr_en  input  1  write strobe from integer writeback stage.
REQ-009 rd  input  5  write destination index from writeback.
REQ-010 data_in  input  32  write data from writeback.
REQ-011 issue_en  input  1  an op targeting issue_rd is issued this cycle.
REQ-012 issue_rd  input  5  destination of the issuing op.
REQ-013 rs1_busy  output  1  rs1_addr has an outstanding producer.
REQ-014 rs2_busy  output  1  rs2_addr has an outstanding producer.
REQ-015 issue_hazard  output  1  issue_en targets a register that is still busy (WAW).
REQ-016 busy_vec  output  32  registered busy bits, bit n = register n.

Function
REQ-017 Storage: 31 writable 32-bit registers, indices 1..31; index 0 has no storage.
REQ-018 Reads of index 0 SHALL return 0 on either port regardless of writes or bypass.
REQ-019 Write: at rising clk with wr_en=1 and rd!=0, reg[rd] <= data_in; rd=0 writes are discarded.
REQ-020 Write latency: a write is visible in stored state one cycle after the strobe.
REQ-021 BYPASS=1: if wr_en=1, rd!=0 and rd==rsN_addr, rsN_data = data_in in that same cycle; otherwise rsN_data = reg[rsN_addr].
REQ-022 BYPASS=0: rsN_data = reg[rsN_addr] always (no forwarding).
REQ-023 Both read ports are independent; identical addresses on both ports return identical data.
REQ-024 Scoreboard: at rising clk, issue_en=1 with issue_rd!=0 sets busy[issue_rd].
REQ-025 At rising clk, wr_en=1 with rd!=0 clears busy[rd].
REQ-026 Simultaneous issue and writeback to the same index: set wins (busy stays 1, new producer).
REQ-027 Simultaneous issue and writeback to different indices: both updates take effect.
REQ-028 busy[0] SHALL always be 0; issue_rd=0 or rd=0 has no scoreboard effect.
REQ-029 BYPASS=1: rsN_busy = busy[rsN_addr] AND NOT (wr_en AND rd==rsN_addr); BYPASS=0: rsN_busy = busy[rsN_addr] OR (wr_en AND rd==rsN_addr AND rd!=0).
REQ-030 issue_hazard = issue_en AND issue_rd!=0 AND busy[issue_rd] AND NOT (wr_en AND rd==issue_rd); combinational, no effect on state.
REQ-031 busy_vec reflects the registered busy bits only (no same-cycle terms).
REQ-032 Writeback to a non-busy register is legal: data written, busy unchanged (stays 0).

Reset
REQ-033 rst_n low SHALL immediately clear all registers 1..31 to 0 and all busy bits to 0, independent of clk.
REQ-034 During reset rs1_data, rs2_data read 0 (BYPASS=0 path); BYPASS=1 forwarding of data_in remains combinational and is permitted.
REQ-035 Writes and issues presented while rst_n is low SHALL be ignored; first update occurs on the first rising clk with rst_n high.
REQ-036 Reset asserted mid-operation discards all outstanding busy bits; no state survives.

Verification
REQ-037 Reset then read all indices on both ports -> all 0, busy_vec=0.
REQ-038 wr_en=1, rd=5, data_in=0xDEADBEEF, rs1_addr=5 same cycle -> rs1_data=0xDEADBEEF (BYPASS=1) / 0 (BYPASS=0); next cycle 0xDEADBEEF in both.
REQ-039 wr_en=1, rd=0, data_in=0xFFFFFFFF; next cycle rs1_addr=rs2_addr=0 -> both 0; issue_rd=0 -> busy_vec=0.
REQ-040 issue_en rd=7 cycle N -> busy_vec[7]=1 at N+1, rs2_busy=1 with rs2_addr=7; writeback rd=7 at N+3 -> rs2_busy=0 that cycle (BYPASS=1), busy_vec[7]=0 at N+4.
REQ-041 busy[9]=1; same cycle issue_rd=9 and wr_en rd=9 data 0x1234 -> issue_hazard=0, reg[9]=0x1234, busy_vec[9]=1 next cycle; issue_rd=9 alone next cycle -> issue_hazard=1.
REQ-042 busy[3]=1, reg[3]=0x55; assert rst_n low between edges -> reg[3]=0 and busy_vec=0 immediately, before next clk.
